io_input_hub: RTL

//  Parametrised memory-mapped input controller for the board buttons and switches on the CPU IO_BUS.
//  - Synchronises and debounces NBTN buttons and NSW switches.
//  - Latches button press events in sticky bits and raises a maskable irq.
//  - Replaces the direct wiring of raw butu/butd/butl/butr/butc into the CPU core.

---
 rtl/io_pkg.sv | 16 +
 rtl/io_debounce.sv | 47 ++++
 rtl/io_input_hub.sv | 135 +++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared constants for the IO_BUS input hub: bus widths, register offsets and
// the default debounce interval.
package io_pkg;

  localparam int IO_ADDR_W = 16;
  localparam int IO_DATA_W = 32;

  localparam logic [3:0] IO_OFS_BTN = 4'h0;
  localparam logic [3:0] IO_OFS_SW  = 4'h4;
  localparam logic [3:0] IO_OFS_EVT = 4'h8;
  localparam logic [3:0] IO_OFS_MSK = 4'hC;

  // 10 ms at 100 MHz
  localparam int IO_DB_CYCLES_DEF = 1000000;

endpackage

// File: rtl/io_debounce.sv
// One input channel: 2-FF synchroniser, stability counter, accepted level and
// a single-cycle pulse coincident with the edge where the level rises.
module io_debounce
  import io_pkg::*;
#(
  parameter int DB_CYCLES = IO_DB_CYCLES_DEF
)(
  input  logic clk,
  input  logic rstn,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (sync_p1 != level) && (cnt == CNT_LAST);
  assign rise   = accept && sync_p1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
    end else begin
      // synchroniser stage boundary
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_input_hub.sv
// Memory-mapped button/switch controller with debounce, sticky press events and
// a maskable irq. Optional AUTOREPEAT_EN re-raises events while a button is held.
module io_input_hub
  import io_pkg::*;
#(
  parameter int NBTN = 5,
  parameter int NSW  = 16,
  parameter int DB_CYCLES = IO_DB_CYCLES_DEF,
  parameter logic [IO_ADDR_W-1:0] BASE_ADDR = 16'h0100
`ifdef AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
`endif
)(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NBTN-1:0]      btn_raw,
  input  logic [NSW-1:0]       sw_raw,
  input  logic [IO_ADDR_W-1:0] io_addr,
  input  logic                 io_we,
  input  logic                 io_rd,
  input  logic [IO_DATA_W-1:0] io_dout,
  output logic [IO_DATA_W-1:0] io_din,
  output logic [NBTN-1:0]      btn_level,
  output logic [NSW-1:0]       sw_level,
  output logic                 irq
);

  logic [NBTN-1:0]      btn_rise;
  logic [NBTN-1:0]      rpt_pulse;
  logic [NBTN-1:0]      evt;
  logic [NBTN-1:0]      msk;
  logic [NBTN-1:0]      evt_clr;
  logic [NSW-1:0]       sw_rise_unused;
  logic                 hit;
  logic [3:0]           ofs;
  logic                 wr_evt;
  logic                 wr_msk;
  logic [IO_DATA_W-1:0] rd_data;
  logic                 dout_unused;

  assign hit         = (io_addr[15:4] == BASE_ADDR[15:4]);
  assign ofs         = io_addr[3:0];
  assign wr_evt      = io_we && hit && (ofs == IO_OFS_EVT);
  assign wr_msk      = io_we && hit && (ofs == IO_OFS_MSK);
  assign evt_clr     = wr_evt ? io_dout[NBTN-1:0] : '0;
  assign dout_unused = &{1'b0, io_dout};

`ifdef AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
`endif

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rstn  (rstn),
      .raw   (btn_raw[i]),
      .level (btn_level[i]),
      .rise  (btn_rise[i])
    );
`ifdef AUTOREPEAT_EN
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_armed;

    // First repeat waits REPEAT_DELAY after the press, later ones REPEAT_PERIOD
    assign rpt_pulse[i] = btn_level[i] &&
                          (rpt_armed ? (rpt_cnt == RPT_W'(REPEAT_PERIOD - 1))
                                     : (rpt_cnt == RPT_W'(REPEAT_DELAY - 1)));

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b0;
      end else if (!btn_level[i]) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b0;
      end else if (rpt_pulse[i]) begin
        rpt_cnt   <= '0;
        rpt_armed <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 1'b1;
      end
    end
`endif
  end

`ifndef AUTOREPEAT_EN
  assign rpt_pulse = '0;
`endif

  for (genvar j = 0; j < NSW; j++) begin : g_sw
    io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rstn  (rstn),
      .raw   (sw_raw[j]),
      .level (sw_level[j]),
      .rise  (sw_rise_unused[j])
    );
  end

  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (ofs)
        IO_OFS_BTN: rd_data[NBTN-1:0] = btn_level;
        IO_OFS_SW:  rd_data[NSW-1:0]  = sw_level;
        IO_OFS_EVT: rd_data[NBTN-1:0] = evt;
        IO_OFS_MSK: rd_data[NBTN-1:0] = msk;
        default:    rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evt    <= '0;
      msk    <= '0;
      irq    <= 1'b0;
      io_din <= '0;
    end else begin
      // new presses override a simultaneous write-1-to-clear
      evt <= (evt & ~evt_clr) | btn_rise | rpt_pulse;
      if (wr_msk) begin
        msk <= io_dout[NBTN-1:0];
      end
      irq <= |(evt & msk);
      if (io_rd) begin
        io_din <= rd_data;
      end
    end
  end

endmodule
